drm_fifo_ctrl: RTL

Synchronous FIFO controller that turns one `drm_8x4096` simple-dual-port block RAM into a first-word-fall-through stream FIFO with valid/ready handshakes on both sides. It owns the RAM write and read address generation, occupancy accounting, and a small output skid buffer. The skid buffer hides the RAM read latency, so the FIFO sustains one word per clock in and out. It sits between a producer and a consumer that share a single clock, for example UART/DMA byte buffering in the Pango shell.

---
 rtl/drm_fifo_pkg.sv | 30 +++
 rtl/drm_fifo_skid.sv | 59 +++++
 rtl/drm_fifo_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/drm_fifo_pkg.sv
// drm_fifo_pkg: shared constants and helpers for the drm_fifo_ctrl slice.
// Build option: define DRM_FIFO_CTRL_OREG_EN when the block RAM is built with
// OUTPUT_REG=1 (read latency 2, skid depth 3). Otherwise latency 1, skid depth 2.
package drm_fifo_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 12;

`ifdef DRM_FIFO_CTRL_OREG_EN
  localparam int unsigned RD_LAT = 2;
`else
  localparam int unsigned RD_LAT = 1;
`endif

  // One skid slot per in-flight read plus the word being presented.
  localparam int unsigned SKID_DEPTH = RD_LAT + 1;
  localparam int unsigned SKID_IDX_W = $clog2(SKID_DEPTH);
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // Level must hold 2**aw RAM words plus the skid and in-flight words.
  function automatic int unsigned level_width(input int unsigned aw);
    return aw + 2;
  endfunction

  typedef logic [level_width(DEF_ADDR_WIDTH)-1:0] level_t;

endpackage

// File: rtl/drm_fifo_skid.sv
// drm_fifo_skid: SKID_DEPTH-entry register FIFO that absorbs RAM read data.
// Ports: clk, rst (async, active-high), flush (sync clear), push/push_data
// (write a word), pop (remove head), head (current head word), occ (entries held).
// Build option: depth follows DRM_FIFO_CTRL_OREG_EN through drm_fifo_pkg.
module drm_fifo_skid
  import drm_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [SKID_CNT_W-1:0] occ
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [SKID_IDX_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [SKID_CNT_W-1:0] occ_q, occ_d;

  // Depth need not be a power of two, so indices wrap explicitly.
  function automatic logic [SKID_IDX_W-1:0] nxt(input logic [SKID_IDX_W-1:0] i);
    return (i == SKID_IDX_W'(SKID_DEPTH - 1)) ? '0 : i + SKID_IDX_W'(1);
  endfunction

  // Next-state for indices and occupancy.
  always_comb begin
    wr_idx_d = push ? nxt(wr_idx_q) : wr_idx_q;
    rd_idx_d = pop ? nxt(rd_idx_q) : rd_idx_q;
    occ_d    = occ_q + SKID_CNT_W'(push) - SKID_CNT_W'(pop);
    if (flush) begin
      wr_idx_d = '0;
      rd_idx_d = '0;
      occ_d    = '0;
    end
  end

  // State registers and storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      occ_q    <= '0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      occ_q    <= occ_d;
      if (push && !flush) mem_q[wr_idx_q] <= push_data;
    end
  end

  assign head = mem_q[rd_idx_q];
  assign occ  = occ_q;

endmodule

// File: rtl/drm_fifo_ctrl.sv
// drm_fifo_ctrl: first-word-fall-through stream FIFO around one simple-dual-port
// block RAM. Owns RAM addressing, occupancy accounting and an output skid buffer.
// Ports: clk, rst (async, active-high), flush (sync clear);
//   producer s_valid/s_ready/s_data; consumer m_valid/m_ready/m_data;
//   level/almost_full/almost_empty (registered status);
//   ram_wr_en/ram_wr_addr/ram_wr_data/ram_rd_addr/ram_rd_data/ram_rst to the RAM.
// Build option: DRM_FIFO_CTRL_OREG_EN selects RAM read latency 2 (OUTPUT_REG=1).
module drm_fifo_ctrl
  import drm_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AF_LEVEL   = 4032,
  parameter int unsigned AE_LEVEL   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [ADDR_WIDTH+1:0]   level,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    ram_wr_en,
  output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
  output logic [DATA_WIDTH-1:0]   ram_wr_data,
  output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data,
  output logic                    ram_rst
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam int unsigned LW = level_width(ADDR_WIDTH);
  localparam int unsigned CW = SKID_CNT_W + 1;

  logic              rst_q;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     ram_level, ram_level_d;
  logic [RD_LAT-1:0] pend_q, pend_d;
  logic [LW-1:0]     level_q, level_d;
  logic              af_q, af_d, ae_q, ae_d;
  logic [SKID_CNT_W-1:0] skid_occ;
  logic [CW-1:0]     pend_cnt, pend_cnt_d, credit, occ_d;
  logic              push, pop, issue, capture, ram_full;

  assign ram_level = wr_ptr_q - rd_ptr_q;
  assign ram_full  = (ram_level == PW'(depth(ADDR_WIDTH)));

  assign s_ready = !rst_q && !flush && !ram_full;
  assign push    = s_valid && s_ready;
  assign m_valid = (skid_occ != '0);
  assign pop     = m_valid && m_ready;
  assign capture = pend_q[RD_LAT-1];

  // Reads outstanding in the pending shift register.
  always_comb begin
    pend_cnt = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) pend_cnt = pend_cnt + CW'(pend_q[i]);
  end

  // Issue only if the word will have a skid slot when it lands.
  assign credit = CW'(skid_occ) + pend_cnt - CW'(pop);
  assign issue  = !flush && (ram_level != '0) && (credit < CW'(SKID_DEPTH));

  // Next-state for pointers, pending bits and registered status.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(issue);
    pend_d    = '0;
    pend_d[0] = issue;
    for (int unsigned i = 1; i < RD_LAT; i++) pend_d[i] = pend_q[i-1];
    occ_d = CW'(skid_occ) + CW'(capture) - CW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pend_d   = '0;
      occ_d    = '0;
    end
    ram_level_d = wr_ptr_d - rd_ptr_d;
    pend_cnt_d  = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) pend_cnt_d = pend_cnt_d + CW'(pend_d[i]);
    level_d = LW'(ram_level_d) + LW'(pend_cnt_d) + LW'(occ_d);
    af_d    = (level_d >= LW'(AF_LEVEL));
    ae_d    = (level_d <= LW'(AE_LEVEL));
  end

  // State registers; rst_q holds s_ready low for one edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pend_q   <= '0;
      level_q  <= '0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      rst_q    <= 1'b0;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pend_q   <= pend_d;
      level_q  <= level_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  drm_fifo_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (capture),
    .push_data (ram_rd_data),
    .pop       (pop),
    .head      (m_data),
    .occ       (skid_occ)
  );

  assign level        = level_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign ram_wr_en    = push;
  assign ram_wr_addr  = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_wr_data  = s_data;
  assign ram_rd_addr  = rd_ptr_q[ADDR_WIDTH-1:0];
  assign ram_rst      = rst;

endmodule
